// File: rtl/ras_restore_ctrl_pkg.sv
// Shared return-address-stack types: pointer/flag bundle used by the RAS
// and by the restore sequencer for its snapshot and load bundle.
package ras_restore_ctrl_pkg;

   localparam int BP_RAS_SIZE      = 16;
   localparam int BP_RAS_ADDR_BITS = $clog2(BP_RAS_SIZE);
   localparam int BP_OVF_BITS      = BP_RAS_SIZE;

   typedef logic [BP_RAS_ADDR_BITS-1:0] ras_addr_t;

   typedef struct packed {
      ras_addr_t              top;
      logic                   empty;
      logic                   overflow;
      logic [BP_OVF_BITS-1:0] ovf_cnt;
   } ras_state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SNAP,
      ST_COPY,
      ST_LOAD
   } restore_state_t;

endpackage

// File: rtl/ras_restore_ctrl.sv
// Rebuilds the speculative RAS from the committed backup after a flush:
// snapshot backup pointers, copy entries 0..top, then strobe a state load.
module ras_restore_ctrl
   import ras_restore_ctrl_pkg::*;
#(
   parameter int RAS_SIZE      = BP_RAS_SIZE,
   parameter int RAS_ADDR_BITS = $clog2(RAS_SIZE),
   parameter int OVF_BITS      = RAS_SIZE
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     exe_push_i,
   input  logic                     exe_pop_i,
   output logic                     exe_push_o,
   output logic                     exe_pop_o,
   input  logic [RAS_ADDR_BITS-1:0] bk_top_i,
   input  logic                     bk_empty_i,
   input  logic                     bk_overflow_i,
   input  logic [OVF_BITS-1:0]      bk_ovf_cnt_i,
   output logic [RAS_ADDR_BITS-1:0] bk_rd_addr,
   input  logic [31:0]              bk_rd_data,
   output logic                     spec_wr_en,
   output logic [RAS_ADDR_BITS-1:0] spec_wr_addr,
   output logic [31:0]              spec_wr_data,
   output logic                     spec_load,
   output logic [RAS_ADDR_BITS-1:0] spec_top_o,
   output logic                     spec_empty_o,
   output logic                     spec_overflow_o,
   output logic [OVF_BITS-1:0]      spec_ovf_cnt_o,
   output logic                     busy,
   output logic                     bk_hold,
   output logic                     done
);

   restore_state_t state;
   ras_addr_t      idx;
   ras_state_t     snap;
   ras_state_t     load_q;
   ras_state_t     bk_state;
   logic           wr_en_q;
   logic           load_strobe_q;
   logic           hold_q;

   assign bk_state = '{top: bk_top_i, empty: bk_empty_i,
                       overflow: bk_overflow_i, ovf_cnt: bk_ovf_cnt_i};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= ST_IDLE;
         idx           <= '0;
         snap          <= '0;
         load_q        <= '0;
         wr_en_q       <= 1'b0;
         load_strobe_q <= 1'b0;
         hold_q        <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle so each set below is a single-cycle pulse.
         wr_en_q       <= 1'b0;
         load_strobe_q <= 1'b0;
         load_q        <= '0;
         if (flush) begin
            state  <= ST_SNAP;
            idx    <= '0;
            hold_q <= 1'b1;
         end else begin
            unique case (state)
               ST_IDLE: ;
               ST_SNAP: begin
                  snap <= bk_state;
                  idx  <= '0;
                  if (bk_empty_i) begin
                     state         <= ST_LOAD;
                     load_strobe_q <= 1'b1;
                     load_q        <= bk_state;
                  end else begin
                     state   <= ST_COPY;
                     wr_en_q <= 1'b1;
                  end
               end
               ST_COPY: begin
                  // idx returns to 0 on exit so the address outputs idle at zero
                  if (idx == snap.top) begin
                     state         <= ST_LOAD;
                     idx           <= '0;
                     load_strobe_q <= 1'b1;
                     load_q        <= snap;
                  end else begin
                     idx     <= idx + 1'b1;
                     wr_en_q <= 1'b1;
                  end
               end
               ST_LOAD: begin
                  state  <= ST_IDLE;
                  hold_q <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bk_rd_addr      = idx;
   assign spec_wr_en      = wr_en_q;
   assign spec_wr_addr    = idx;
   assign spec_wr_data    = wr_en_q ? bk_rd_data : 32'd0;
   assign spec_load       = load_strobe_q;
   assign done            = load_strobe_q;
   assign spec_top_o      = load_q.top;
   assign spec_empty_o    = load_q.empty;
   assign spec_overflow_o = load_q.overflow;
   assign spec_ovf_cnt_o  = load_q.ovf_cnt;
   assign bk_hold         = hold_q;
   assign busy            = flush | hold_q;
   assign exe_push_o      = exe_push_i & ~busy;
   assign exe_pop_o       = exe_pop_i & ~busy;

endmodule

// File: tb/tb_ras_restore_ctrl.sv
// Scoreboard bench for ras_restore_ctrl: a backup-RAS model feeds the DUT,
// expected writes/loads are queued at flush time and matched by a monitor.
module tb_ras_restore_ctrl;
   import ras_restore_ctrl_pkg::*;

   localparam int AW = BP_RAS_ADDR_BITS;
   localparam int OW = BP_OVF_BITS;
   localparam int N  = BP_RAS_SIZE;

   logic          clk = 1'b0;
   logic          resetn, flush, exe_push_i, exe_pop_i, exe_push_o, exe_pop_o;
   ras_addr_t     bk_top;
   logic          bk_empty, bk_overflow;
   logic [OW-1:0] bk_ovf_cnt;
   ras_addr_t     bk_rd_addr, spec_wr_addr, spec_top_o;
   logic [31:0]   bk_rd_data, spec_wr_data;
   logic          spec_wr_en, spec_load, spec_empty_o, spec_overflow_o;
   logic [OW-1:0] spec_ovf_cnt_o;
   logic          busy, bk_hold, done;
   logic [31:0]   bk_mem [N];

   typedef struct { int cyc; ras_addr_t addr; logic [31:0] data; } exp_wr_t;
   typedef struct { int cyc; ras_state_t st; } exp_load_t;

   exp_wr_t   wr_q[$];
   exp_load_t ld_q[$];
   exp_wr_t   mon_w;
   exp_load_t mon_l;
   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bk_rd_data = bk_mem[bk_rd_addr];

   ras_restore_ctrl dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .exe_push_i(exe_push_i), .exe_pop_i(exe_pop_i),
      .exe_push_o(exe_push_o), .exe_pop_o(exe_pop_o),
      .bk_top_i(bk_top), .bk_empty_i(bk_empty), .bk_overflow_i(bk_overflow),
      .bk_ovf_cnt_i(bk_ovf_cnt), .bk_rd_addr(bk_rd_addr), .bk_rd_data(bk_rd_data),
      .spec_wr_en(spec_wr_en), .spec_wr_addr(spec_wr_addr), .spec_wr_data(spec_wr_data),
      .spec_load(spec_load), .spec_top_o(spec_top_o), .spec_empty_o(spec_empty_o),
      .spec_overflow_o(spec_overflow_o), .spec_ovf_cnt_o(spec_ovf_cnt_o),
      .busy(busy), .bk_hold(bk_hold), .done(done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes or loads.
   always @(negedge clk) begin
      if (spec_wr_en) begin
         if (wr_q.size() == 0) check("wr_unexpected", 64'(spec_wr_en), 64'd0);
         else begin
            mon_w = wr_q.pop_front();
            check("wr_cycle", 64'(cyc), 64'(mon_w.cyc));
            check("wr_addr", 64'(spec_wr_addr), 64'(mon_w.addr));
            check("wr_data", 64'(spec_wr_data), 64'(mon_w.data));
         end
      end
      if (spec_load) begin
         if (ld_q.size() == 0) check("load_unexpected", 64'(spec_load), 64'd0);
         else begin
            mon_l = ld_q.pop_front();
            check("load_cycle", 64'(cyc), 64'(mon_l.cyc));
            check("load_state", 64'({spec_top_o, spec_empty_o, spec_overflow_o, spec_ovf_cnt_o}),
                  64'(mon_l.st));
            check("load_done", 64'(done), 64'd1);
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue what a restore of the current backup model must produce for a flush at cycle t.
   task automatic push_expect(input int t, output int load_cyc);
      exp_wr_t   w;
      exp_load_t l;
      l.st = '{top: bk_top, empty: bk_empty, overflow: bk_overflow, ovf_cnt: bk_ovf_cnt};
      if (bk_empty) l.cyc = t + 2;
      else begin
         for (int i = 0; i <= int'(bk_top); i++) begin
            w.cyc  = t + 2 + i;
            w.addr = ras_addr_t'(i);
            w.data = bk_mem[i];
            wr_q.push_back(w);
         end
         l.cyc = t + 3 + int'(bk_top);
      end
      ld_q.push_back(l);
      load_cyc = l.cyc;
   endtask

   task automatic restore(input bit push_too, input logic [31:0] pdata);
      int t, last;
      @(posedge clk);
      #1;
      t          = cyc;
      flush      = 1'b1;
      exe_push_i = 1'b1;
      #1;
      check("exe_push_gated_flush", 64'(exe_push_o), 64'd0);
      check("busy_flush_cycle", 64'(busy), 64'd1);
      if (push_too) check("bk_hold_at_commit", 64'(bk_hold), 64'd0);
      @(posedge clk);
      if (push_too) begin
         bk_top         = bk_top + 1'b1;
         bk_mem[bk_top] = pdata;
      end
      #1;
      flush = 1'b0;
      push_expect(t, last);
      #1;
      check("exe_push_gated_busy", 64'(exe_push_o), 64'd0);
      check("bk_hold_snap", 64'(bk_hold), 64'd1);
      wait_cyc(last);
      check("busy_in_load", 64'(busy), 64'd1);
      wait_cyc(last + 1);
      check("busy_after_load", 64'(busy), 64'd0);
      check("bk_hold_after_load", 64'(bk_hold), 64'd0);
      check("exe_push_passthru", 64'(exe_push_o), 64'd1);
      exe_push_i = 1'b0;
      check("wr_q_drained", 64'(wr_q.size()), 64'd0);
      check("ld_q_drained", 64'(ld_q.size()), 64'd0);
      check("spec_o_idle", 64'({spec_top_o, spec_empty_o, spec_overflow_o, spec_ovf_cnt_o}), 64'd0);
   endtask

   task automatic set_backup(input int top, input bit empty, input bit ovf, input int cnt);
      bk_top      = ras_addr_t'(top);
      bk_empty    = empty;
      bk_overflow = ovf;
      bk_ovf_cnt  = OW'(cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int t, last;
      exp_wr_t w;
      resetn = 1'b0; flush = 1'b0; exe_push_i = 1'b1; exe_pop_i = 1'b1;
      set_backup(0, 1'b1, 1'b0, 0);
      for (int i = 0; i < N; i++) bk_mem[i] = 32'h1000_0000 + 32'(i * 4);
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_bk_hold", 64'(bk_hold), 64'd0);
      check("rst_wr_en", 64'(spec_wr_en), 64'd0);
      check("rst_load_done", 64'({spec_load, done}), 64'd0);
      check("rst_passthru", 64'({exe_push_o, exe_pop_o}), 64'h3);
      exe_push_i = 1'b0; exe_pop_i = 1'b0;
      resetn = 1'b1;

      // Three committed entries.
      bk_mem[0] = 32'h0000_00A0; bk_mem[1] = 32'h0000_00A4; bk_mem[2] = 32'h0000_00A8;
      set_backup(2, 1'b0, 1'b0, 0);
      restore(1'b0, 32'd0);

      // Empty backup: straight to LOAD.
      set_backup(0, 1'b1, 1'b0, 0);
      restore(1'b0, 32'd0);

      // Overflowed backup: all entries copied.
      for (int i = 0; i < N; i++) bk_mem[i] = $urandom;
      set_backup(N - 1, 1'b0, 1'b1, 3);
      restore(1'b0, 32'd0);

      // Commit push landing at the flush edge.
      set_backup(2, 1'b0, 1'b0, 0);
      restore(1'b1, 32'hDEAD_BEEF);

      // Second flush while COPY is at index 1.
      for (int i = 0; i < N; i++) bk_mem[i] = $urandom;
      set_backup(4, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      t = cyc; flush = 1'b1; exe_pop_i = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         w.cyc = t + 2 + i; w.addr = ras_addr_t'(i); w.data = bk_mem[i];
         wr_q.push_back(w);
      end
      wait_cyc(t + 3);
      check("restart_copy_idx", 64'(bk_rd_addr), 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      push_expect(t + 3, last);
      check("exe_pop_gated", 64'(exe_pop_o), 64'd0);
      wait_cyc(last + 1);
      check("restart_busy_after", 64'(busy), 64'd0);
      check("restart_wr_drained", 64'(wr_q.size()), 64'd0);
      check("restart_ld_drained", 64'(ld_q.size()), 64'd0);
      exe_pop_i = 1'b0;

      // Reset in the middle of COPY.
      set_backup(5, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      t = cyc; flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         w.cyc = t + 2 + i; w.addr = ras_addr_t'(i); w.data = bk_mem[i];
         wr_q.push_back(w);
      end
      wait_cyc(t + 3);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_bk_hold", 64'(bk_hold), 64'd0);
      check("midrst_wr_en", 64'(spec_wr_en), 64'd0);
      resetn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("midrst_wr_drained", 64'(wr_q.size()), 64'd0);
      check("midrst_idle_busy", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ras_restore_ctrl.md
Name: ras_restore_ctrl

Overview:
- Sequences recovery of the speculative return-address stack after a pipeline flush: copies the committed (backup) stack contents and pointer state into the speculative stack.
- Sits beside the RAS; drives the speculative RAM write port and state-load strobe, reads the backup RAM.
- Gates exe-stage push/pop and F1 prediction while recovery runs, and holds commit-side backup updates.

Parameters:
- RAS_SIZE, 16, stack depth; power of two, ≥2.
- RAS_ADDR_BITS, $clog2(RAS_SIZE), stack pointer width (derived).
- OVF_BITS, RAS_SIZE, overflow counter width (derived).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- flush  in  1  pipeline flush / mispredict redirect
- exe_push_i, exe_pop_i  in  1 each  speculative push/pop from exe
- exe_push_o, exe_pop_o  out  1 each  gated push/pop to RAS; exe_*_i & ~busy
- bk_top_i  in  RAS_ADDR_BITS  backup top pointer
- bk_empty_i, bk_overflow_i  in  1 each  backup empty/overflow flags
- bk_ovf_cnt_i  in  OVF_BITS  backup overflow counter
- bk_rd_addr  out  RAS_ADDR_BITS  backup RAM read address; read is combinational, zero latency
- bk_rd_data  in  32  backup RAM read data
- spec_wr_en  out  1  speculative RAM write enable
- spec_wr_addr  out  RAS_ADDR_BITS  speculative RAM write address
- spec_wr_data  out  32  speculative RAM write data
- spec_load  out  1  one-cycle strobe: RAS loads top/empty/overflow/counter below; overrides all other RAS updates
- spec_top_o, spec_empty_o, spec_overflow_o, spec_ovf_cnt_o  out  as bk_*  values to load
- busy  out  1  flush | (state != IDLE); RAS masks hit and ignores fail while high
- bk_hold  out  1  state != IDLE; commit stage must not issue bk_push/bk_pop while high
- done  out  1  pulses in the LOAD cycle

Behaviour:
- Reset: state IDLE, index 0, snapshot 0. All outputs 0 except gated passthroughs, which follow the inputs (busy=0). Reset overrides any operation in progress.
- FSM states: IDLE, SNAP, COPY, LOAD.
- IDLE: flush → SNAP. A commit bk_push/bk_pop in the flush cycle is allowed and lands at that edge.
- SNAP (1 cycle): register bk_top_i, bk_empty_i, bk_overflow_i, bk_ovf_cnt_i; index ← 0. Next: LOAD if bk_empty_i, else COPY.
- COPY (one entry per cycle):
  - bk_rd_addr = index; spec_wr_en = 1; spec_wr_addr = index; spec_wr_data = bk_rd_data.
  - index == snap_top → LOAD; else index + 1.
  - Copies entries 0..snap_top inclusive. Overflow case: snap_top is all-ones, so all RAS_SIZE entries are copied.
- LOAD (1 cycle): spec_load = 1, done = 1, spec_*_o = snapshot → IDLE.
- Outside LOAD, spec_*_o = 0; outside COPY, spec_wr_en = 0 and addresses/data = 0.
- Latency: flush at cycle T, SNAP at T+1, COPY at T+2..T+2+top, LOAD at T+3+top, IDLE at T+4+top.
  - Empty backup: LOAD at T+2.
  - busy is high from T through LOAD inclusive.
- flush in SNAP/COPY/LOAD → SNAP next cycle (restart; the in-flight LOAD's spec_load is still emitted that cycle, and the restart overwrites it). Back-to-back flushes just keep restarting.
- bk_push/bk_pop while bk_hold is a protocol violation; the bench flags it. The block does not buffer them.
- exe push/pop while busy are dropped (wrong-path).
- Index never exceeds RAS_SIZE-1; no wrap.

Decomposition:
- Shared bp package: ras_addr_t, RAS_SIZE default, ras_state_t struct {top, empty, overflow, ovf_cnt} used for the snapshot and the load bundle. The RAS module consumes the same struct.
- No sub-module; single FSM plus snapshot register.

Test Plan:
- Backup holds 3 entries (top=2, A0/A4/A8), flush at T → spec writes addr 0,1,2 = A0,A4,A8 at T+2..T+4; spec_load at T+5 with top=2, empty=0; busy low at T+6.
- Backup empty, flush → no spec_wr_en; spec_load at T+2 with empty=1, top=0, overflow=0.
- Backup overflowed (top=15, ovf_cnt=3) → 16 writes at T+2..T+17; LOAD at T+18 with overflow=1, ovf_cnt=3.
- Second flush during COPY at index 1 → SNAP next cycle, copy restarts from index 0, exactly one final LOAD.
- exe_push_i=1 during busy → exe_push_o=0; commit bk_push coincident with flush → snapshot reflects top+1.
- resetn low at mid-COPY → next cycle state IDLE, busy/bk_hold/spec_wr_en all 0.
